// File: rtl/plot_fifo.sv
// Plot-request FIFO between the draw mux and the VGA adapter wrapper.
// Clips off-screen pixels, counts clipped and overflow-dropped plots.
module plot_fifo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int X_MAX  = 159,
   parameter int Y_MAX  = 119
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [9:0]        in_x,
   input  logic [9:0]        in_y,
   input  logic [2:0]        in_colour,
   input  logic              in_plot,
   input  logic              flush,
   input  logic              drain_en,
   output logic              in_ready,
   output logic [9:0]        out_x,
   output logic [9:0]        out_y,
   output logic [2:0]        out_colour,
   output logic              out_plot,
   output logic [ADDR_W:0]   level,
   output logic [7:0]        clip_count,
   output logic [7:0]        drop_count
);

   localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [9:0]      X_LIM    = 10'(X_MAX);
   localparam logic [9:0]      Y_LIM    = 10'(Y_MAX);

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic [22:0]       mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [ADDR_W:0]   lvl;
   logic [9:0]        x_p1, y_p1;
   logic [2:0]        colour_p1;
   logic              vld_p1;
   logic [7:0]        clip_cnt, drop_cnt;

   logic legal, full, pop_req, pop, push, clip_hit, drop_hit;

   // Stage 0: clip check and push/pop arbitration
   always_comb begin
      legal    = (in_x <= X_LIM) && (in_y <= Y_LIM);
      full     = (lvl == LVL_FULL);
      pop_req  = drain_en && (lvl != '0);
      pop      = pop_req && !flush;
      // A pop in the same cycle frees a slot, so a full FIFO can still accept.
      push     = in_plot && legal && (!full || pop_req) && !flush;
      clip_hit = in_plot && !legal;
      drop_hit = in_plot && legal && full && !pop_req;
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {in_colour, in_y, in_x};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         lvl    <= '0;
         vld_p1 <= 1'b0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         lvl    <= '0;
         vld_p1 <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + ADDR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + ADDR_W'(1);
         case ({push, pop})
            2'b10:   lvl <= lvl + (ADDR_W+1)'(1);
            2'b01:   lvl <= lvl - (ADDR_W+1)'(1);
            default: lvl <= lvl;
         endcase
         vld_p1 <= pop;
      end
   end

   // Stage 1: registered head entry presented to the adapter
   always_ff @(posedge clk) begin
      if (reset) begin
         x_p1      <= '0;
         y_p1      <= '0;
         colour_p1 <= '0;
      end else if (pop) begin
         {colour_p1, y_p1, x_p1} <= mem[rd_ptr];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         clip_cnt <= '0;
         drop_cnt <= '0;
      end else begin
         if (clip_hit)
            clip_cnt <= sat_inc(clip_cnt);
         if (drop_hit)
            drop_cnt <= sat_inc(drop_cnt);
      end
   end

   assign in_ready   = (lvl != LVL_FULL);
   assign level      = lvl;
   assign out_x      = x_p1;
   assign out_y      = y_p1;
   assign out_colour = colour_p1;
   assign out_plot   = vld_p1;
   assign clip_count = clip_cnt;
   assign drop_count = drop_cnt;

endmodule

// File: tb/tb_plot_fifo.sv
// Scoreboard bench for plot_fifo: directed pushes queue expected plots,
// a negedge monitor checks every out_plot strobe against the queue.
module tb_plot_fifo;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  in_x, in_y;
   logic [2:0]  in_colour;
   logic        in_plot, flush, drain_en;
   logic        in_ready;
   logic [9:0]  out_x, out_y;
   logic [2:0]  out_colour;
   logic        out_plot;
   logic [4:0]  level;
   logic [7:0]  clip_count, drop_count;

   int total = 0;
   int bad   = 0;
   logic [22:0] sb [$];

   plot_fifo dut (
      .clk(clk), .reset(reset),
      .in_x(in_x), .in_y(in_y), .in_colour(in_colour), .in_plot(in_plot),
      .flush(flush), .drain_en(drain_en), .in_ready(in_ready),
      .out_x(out_x), .out_y(out_y), .out_colour(out_colour), .out_plot(out_plot),
      .level(level), .clip_count(clip_count), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_plot(input int x, input int y, input int c, input bit expect_out);
      in_x      = 10'(x);
      in_y      = 10'(y);
      in_colour = 3'(c);
      in_plot   = 1'b1;
      if (expect_out)
         sb.push_back({3'(c), 10'(y), 10'(x)});
   endtask

   // Monitor: every strobe must match the oldest expected plot
   always @(negedge clk) begin
      if (out_plot === 1'b1) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0d expected no plot",
                     out_x, out_y, out_colour);
         end else begin
            logic [22:0] e;
            e = sb.pop_front();
            if ({out_colour, out_y, out_x} !== e) begin
               bad++;
               $display("FAIL plot_data: got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                        out_x, out_y, out_colour, e[9:0], e[19:10], e[22:20]);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; in_x = '0; in_y = '0; in_colour = '0;
      in_plot = 1'b0; flush = 1'b0; drain_en = 1'b0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_level", level, 0);
      chk("rst_ready", in_ready, 1);
      chk("rst_plot", out_plot, 0);
      chk("rst_x", out_x, 0);
      chk("rst_clip", clip_count, 0);
      chk("rst_drop", drop_count, 0);

      // Three buffered plots, then drained in order
      set_plot(10, 20, 1, 1); tick();
      set_plot(11, 20, 2, 1); tick();
      set_plot(12, 20, 3, 1); tick();
      in_plot = 1'b0;
      chk("buf3_level", level, 3);
      chk("buf3_plot", out_plot, 0);
      drain_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("drain3_strobe", out_plot, 1);
      end
      tick();
      chk("drain3_done_plot", out_plot, 0);
      chk("drain3_level", level, 0);
      drain_en = 1'b0;

      // Off-screen plots are clipped; the corner is legal
      set_plot(160, 5, 4, 0);    tick();
      set_plot(5, 120, 4, 0);    tick();
      set_plot(1023, 1023, 4, 0); tick();
      in_plot = 1'b0;
      chk("clip3_count", clip_count, 3);
      chk("clip3_level", level, 0);
      chk("clip3_plot", out_plot, 0);
      set_plot(159, 119, 5, 1); tick();
      in_plot = 1'b0;
      chk("corner_level", level, 1);
      drain_en = 1'b1; tick(); tick();
      drain_en = 1'b0;
      chk("corner_drained", level, 0);

      // Overflow: 20 pushes, last 4 dropped
      for (int i = 0; i < 20; i++) begin
         set_plot(i, 50 + i, i % 8, i < 16);
         tick();
      end
      in_plot = 1'b0;
      chk("full_level", level, 16);
      chk("full_ready", in_ready, 0);
      chk("full_drop", drop_count, 4);

      // Push and pop together while full
      set_plot(100, 100, 6, 1);
      drain_en = 1'b1;
      tick();
      in_plot = 1'b0;
      drain_en = 1'b0;
      chk("pushpop_level", level, 16);
      chk("pushpop_drop", drop_count, 4);
      drain_en = 1'b1;
      repeat (18) tick();
      chk("full_drained_level", level, 0);
      chk("full_drained_sb", sb.size(), 0);

      // Minimum latency into empty FIFO
      set_plot(7, 8, 2, 1);
      tick();
      in_plot = 1'b0;
      chk("lat_n1_plot", out_plot, 0);
      tick();
      chk("lat_n2_plot", out_plot, 1);
      tick();
      chk("lat_n3_plot", out_plot, 0);
      drain_en = 1'b0;

      // Flush with simultaneous push and pop
      for (int i = 0; i < 5; i++) begin
         set_plot(30 + i, 40, 1, 0);
         tick();
      end
      in_plot = 1'b0;
      chk("preflush_level", level, 5);
      set_plot(60, 60, 3, 0);
      drain_en = 1'b1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_plot = 1'b0;
      chk("flush_level", level, 0);
      chk("flush_plot", out_plot, 0);
      chk("flush_clip", clip_count, 3);
      chk("flush_drop", drop_count, 4);
      tick();
      chk("flush_empty_plot", out_plot, 0);
      drain_en = 1'b0;

      // Reset returns all outputs to idle values
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst2_x", out_x, 0);
      chk("rst2_y", out_y, 0);
      chk("rst2_colour", out_colour, 0);
      chk("rst2_plot", out_plot, 0);
      chk("rst2_level", level, 0);
      chk("rst2_ready", in_ready, 1);
      chk("rst2_clip", clip_count, 0);
      chk("rst2_drop", drop_count, 0);

      // Clip counter saturation
      for (int i = 0; i < 300; i++) begin
         set_plot(200, i % 100, 1, 0);
         tick();
         if (i == 253)
            chk("clip_254", clip_count, 254);
      end
      in_plot = 1'b0;
      chk("clip_sat", clip_count, 255);
      chk("clip_sat_level", level, 0);
      chk("clip_sat_drop", drop_count, 0);
      tick();
      chk("end_sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/plot_fifo.md
Name: plot_fifo

Overview:
- Buffers pixel plot requests between the draw multiplexer and the VGA adapter wrapper.
- Decouples draw engines that burst plots (brick, platform, ball, screen fills) from a paced consumer.
- Clips off-screen coordinates before they reach the adapter.
- Counts clipped and overflow-dropped plots for debug LEDs.

Parameters:
- DEPTH, 16, number of plot entries stored; must be a power of two.
- ADDR_W, 4, log2(DEPTH).
- X_MAX, 159, largest legal x coordinate.
- Y_MAX, 119, largest legal y coordinate.

Ports:
- clk  input  1  system clock (CLOCK_50 domain).
- reset  input  1  synchronous, active-high reset.
- in_x  input  10  plot x from draw mux.
- in_y  input  10  plot y from draw mux.
- in_colour  input  3  plot colour.
- in_plot  input  1  plot request, one pixel per cycle while high.
- flush  input  1  discard all buffered entries.
- drain_en  input  1  consumer permits one pop this cycle.
- in_ready  output  1  high when not full.
- out_x  output  10  registered plot x to adapter.
- out_y  output  10  registered plot y to adapter.
- out_colour  output  3  registered plot colour.
- out_plot  output  1  one-cycle plot strobe to adapter.
- level  output  ADDR_W+1  current occupancy, 0..DEPTH.
- clip_count  output  8  saturating count of off-screen plots discarded.
- drop_count  output  8  saturating count of plots lost to overflow.

Behaviour:
- All logic is on the posedge of clk. reset is synchronous, active-high, and overrides everything.
- Reset values:
  - write and read pointers = 0; level = 0; in_ready = 1.
  - out_x = 0, out_y = 0, out_colour = 0, out_plot = 0.
  - clip_count = 0, drop_count = 0.
- Clip check (combinational on inputs): legal iff in_x <= X_MAX and in_y <= Y_MAX, compared as unsigned 10-bit values.
- Per-cycle, when in_plot = 1:
  - Illegal coordinate: entry not stored; clip_count increments, holding at 255.
  - Legal, and (level < DEPTH or a pop occurs this cycle): entry stored at the write pointer, which increments modulo DEPTH.
  - Legal, level == DEPTH and no pop this cycle: entry discarded; drop_count increments, holding at 255.
- Pop:
  - Occurs when drain_en = 1 and level > 0 at the clock edge.
  - The head entry is registered onto out_x/out_y/out_colour; out_plot = 1 on the following cycle only. The read pointer increments modulo DEPTH.
  - No pop means out_plot = 0 next cycle; out_x/out_y/out_colour hold their last values.
- No bypass path. A push at cycle N into an empty FIFO is popped at the earliest at N+1, with out_plot asserted at N+2. Minimum latency is 2 cycles.
- Level update: +1 on push only, -1 on pop only, unchanged on both or neither. It never exceeds DEPTH and never goes below 0.
- in_ready = (level != DEPTH). It is purely combinational from level and is advisory: upstream engines are not stalled, so overflow is counted rather than back-pressured.
- flush:
  - Pointers and level go to 0 at the edge.
  - Any push or pop in the same cycle is ignored, and out_plot = 0 next cycle.
  - clip_count and drop_count are unaffected by flush.
- Pointer wrap-around is implicit modulo DEPTH. Full versus empty is distinguished by level, not pointer equality.
- Storage is a register array of DEPTH x 23 bits ({colour, y, x}). Reads are synchronous via the output register.

Test Plan:
- Reset, then push 3 legal plots (10,20,c1),(11,20,c2),(12,20,c3) with drain_en = 0:
  - level = 3, out_plot = 0.
  - Raise drain_en: out_plot high for 3 consecutive cycles, outputs in push order; level returns to 0.
- Push (160,5), (5,120) and (1023,1023):
  - clip_count = 3, level = 0, no out_plot.
  - Push (159,119): accepted, level = 1.
- Push 20 legal plots with drain_en = 0:
  - level = 16, in_ready = 0, drop_count = 4.
  - Draining 16 entries returns the first 16 pushed, in order.
- At level = 16, push and drain in the same cycle:
  - Push accepted, level stays 16, drop_count unchanged.
  - Push one cycle into empty with drain_en held high: out_plot asserted exactly 2 cycles after the push.
- At level = 5 with counters nonzero, assert flush together with in_plot and drain_en:
  - Next cycle: level = 0, out_plot = 0, counters unchanged.
  - Assert reset: all outputs return to their reset values.
- Force 300 off-screen plots: clip_count saturates at 255 and does not wrap.
